// File: rtl/phi_az_gen.sv
// Autozero phase generator: holds phi_az on through startup, then issues fixed-width
// autozero windows on an external pulse edge or from a periodic timer.
module phi_az_gen #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 16,
    parameter int WID_W          = 8,
    parameter int STARTUP_PULSES = 1
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             pulse,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [WID_W-1:0] az_width,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  phi_az,
    output logic             startup_done,
    output logic             az_busy,
    output logic [7:0]       az_cnt
);

    localparam int EC_W = (STARTUP_PULSES > 1) ? $clog2(STARTUP_PULSES) : 1;
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(STARTUP_PULSES - 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             az_on_q, az_on_d;
    logic             pulse_dly_q, pulse_dly_d;
    logic [EC_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [WID_W-1:0] width_cnt_q, width_cnt_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             startup_done_q, startup_done_d;
    logic             az_busy_q, az_busy_d;
    logic [7:0]       az_cnt_q, az_cnt_d;

    logic rise;
    logic timer_run;
    logic timer_hit;

    assign rise      = pulse & ~pulse_dly_q;
    // The timer only counts post-startup in periodic mode; anywhere else it sits preloaded.
    assign timer_run = (mode == 2'd1) && (period != '0) &&
                       ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
    assign timer_hit = timer_run && (timer_q == CNT_W'(1));

    always_comb begin
        state_d        = state_q;
        az_on_d        = az_on_q;
        pulse_dly_d    = pulse;
        edge_cnt_d     = edge_cnt_q;
        width_cnt_d    = width_cnt_q;
        startup_done_d = startup_done_q;
        az_busy_d      = az_busy_q;
        az_cnt_d       = az_cnt_q;

        if (!timer_run || (timer_q <= CNT_W'(1))) begin
            timer_d = period;
        end else begin
            timer_d = timer_q - CNT_W'(1);
        end

        case (state_q)
            ST_STARTUP: begin
                az_on_d = 1'b1;
                if (rise) begin
                    if (edge_cnt_q == EC_LAST) begin
                        state_d        = ST_IDLE;
                        az_on_d        = 1'b0;
                        startup_done_d = 1'b1;
                        edge_cnt_d     = '0;
                    end else begin
                        edge_cnt_d = edge_cnt_q + EC_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                az_on_d = 1'b0;
                if (((mode == 2'd0) && rise) || timer_hit) begin
                    state_d     = ST_ACTIVE;
                    az_on_d     = 1'b1;
                    az_busy_d   = 1'b1;
                    width_cnt_d = (az_width == '0) ? WID_W'(1) : az_width;
                end
            end
            ST_ACTIVE: begin
                // Window length was latched at the trigger; inputs cannot stretch or cut it.
                if (width_cnt_q <= WID_W'(1)) begin
                    state_d   = ST_IDLE;
                    az_on_d   = 1'b0;
                    az_busy_d = 1'b0;
                    az_cnt_d  = az_cnt_q + 8'd1;
                end else begin
                    width_cnt_d = width_cnt_q - WID_W'(1);
                end
            end
            default: begin
                state_d        = ST_STARTUP;
                az_on_d        = 1'b1;
                edge_cnt_d     = '0;
                startup_done_d = 1'b0;
                az_busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= ST_STARTUP;
            az_on_q        <= 1'b1;
            pulse_dly_q    <= 1'b0;
            edge_cnt_q     <= '0;
            width_cnt_q    <= '0;
            timer_q        <= '0;
            startup_done_q <= 1'b0;
            az_busy_q      <= 1'b0;
            az_cnt_q       <= 8'd0;
        end else begin
            state_q        <= state_d;
            az_on_q        <= az_on_d;
            pulse_dly_q    <= pulse_dly_d;
            edge_cnt_q     <= edge_cnt_d;
            width_cnt_q    <= width_cnt_d;
            timer_q        <= timer_d;
            startup_done_q <= startup_done_d;
            az_busy_q      <= az_busy_d;
            az_cnt_q       <= az_cnt_d;
        end
    end

    assign phi_az       = ch_en & {N_CH{az_on_q | (startup_done_q & (mode == 2'd2))}};
    assign startup_done = startup_done_q;
    assign az_busy      = az_busy_q;
    assign az_cnt       = az_cnt_q;

endmodule

// File: tb/tb_phi_az_gen.sv
// Bench for phi_az_gen: directed scenarios plus random traffic, compared every cycle
// against a window/phase reference model.
module tb_phi_az_gen;

    localparam int SP = 2;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        pulse;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [7:0]  az_width;
    logic [3:0]  ch_en;
    logic [3:0]  phi_az;
    logic        startup_done;
    logic        az_busy;
    logic [7:0]  az_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: startup progress, cycles left in the window, completed windows,
    // and how many cycles periodic mode has been running.
    bit m_done;
    int m_rises;
    int m_win;
    int m_cnt;
    int m_n;
    bit m_prev;

    phi_az_gen #(
        .N_CH(4), .CNT_W(16), .WID_W(8), .STARTUP_PULSES(SP)
    ) dut (
        .clk(clk), .reset_b(reset_b), .pulse(pulse), .mode(mode), .period(period),
        .az_width(az_width), .ch_en(ch_en), .phi_az(phi_az),
        .startup_done(startup_done), .az_busy(az_busy), .az_cnt(az_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_done  = 1'b0;
        m_rises = 0;
        m_win   = 0;
        m_cnt   = 0;
        m_n     = 0;
        m_prev  = 1'b0;
    endtask

    task automatic model_edge();
        bit rise;
        bit hit;
        if (!reset_b) begin
            model_reset();
            return;
        end
        rise = pulse && !m_prev;
        if (!m_done) begin
            m_n = 0;
            if (rise) begin
                m_rises++;
                if (m_rises == SP) m_done = 1'b1;
            end
        end else begin
            hit = 1'b0;
            if (mode == 2'd1 && period != 16'd0) begin
                m_n++;
                hit = ((m_n % int'(period)) == 0);
            end else begin
                m_n = 0;
            end
            if (m_win > 0) begin
                m_win--;
                if (m_win == 0) m_cnt = (m_cnt + 1) % 256;
            end else if ((mode == 2'd0 && rise) || hit) begin
                m_win = (az_width == 8'd0) ? 1 : int'(az_width);
            end
        end
        m_prev = pulse;
    endtask

    task automatic check(input string tag);
        logic [3:0] e_phi;
        logic [7:0] e_cnt;
        e_phi = (!m_done || m_win > 0 || mode == 2'd2) ? ch_en : 4'h0;
        e_cnt = 8'(m_cnt);
        vectors++;
        assert (phi_az === e_phi) else begin
            miscompares++;
            $error("FAIL %s phi_az: observed %h expected %h", tag, phi_az, e_phi);
        end
        vectors++;
        assert (startup_done === m_done) else begin
            miscompares++;
            $error("FAIL %s startup_done: observed %b expected %b", tag, startup_done, m_done);
        end
        vectors++;
        assert (az_busy === (m_win > 0)) else begin
            miscompares++;
            $error("FAIL %s az_busy: observed %b expected %b", tag, az_busy, (m_win > 0));
        end
        vectors++;
        assert (az_cnt === e_cnt) else begin
            miscompares++;
            $error("FAIL %s az_cnt: observed %0d expected %0d", tag, az_cnt, e_cnt);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        logic [15:0] per_tab [5];
        int          new_mode;
        per_tab = '{16'd0, 16'd1, 16'd3, 16'd7, 16'd20};

        reset_b  = 1'b1;
        pulse    = 1'b0;
        mode     = 2'd0;
        period   = 16'd0;
        az_width = 8'd5;
        ch_en    = 4'hF;
        #2;
        reset_b = 1'b0;
        model_reset();
        #1;
        check("reset_async");
        cycles(3, "reset_hold");
        reset_b = 1'b1;

        $display("T1 startup with %0d pulses, first pulse held 10 clk", SP);
        pulse = 1'b1;
        cycles(10, "t1_held");
        pulse = 1'b0;
        cycles(3, "t1_low");
        pulse = 1'b1;
        cycle("t1_second_rise");
        pulse = 1'b0;
        cycles(3, "t1_after");

        $display("T2 external trigger, width 5, ignored retrigger, width 0");
        pulse = 1'b1;
        cycle("t2_trig");
        pulse = 1'b0;
        cycle("t2_win");
        pulse = 1'b1;
        cycle("t2_retrig");
        pulse = 1'b0;
        cycles(6, "t2_tail");
        az_width = 8'd0;
        pulse = 1'b1;
        cycle("t2_w0_trig");
        pulse = 1'b0;
        cycles(3, "t2_w0_tail");

        $display("T3 periodic mode, period 20 width 3, then period 0");
        mode     = 2'd3;
        period   = 16'd20;
        az_width = 8'd3;
        cycle("t3_preload");
        mode = 2'd1;
        cycles(70, "t3_periodic");
        period = 16'd0;
        cycles(30, "t3_period0");

        $display("T4 ch_en mid-window, forced-on mode, off mode");
        mode     = 2'd0;
        az_width = 8'd6;
        pulse    = 1'b1;
        cycle("t4_trig");
        pulse = 1'b0;
        cycle("t4_win");
        ch_en = 4'b0101;
        #1;
        check("t4_chen_comb");
        cycles(6, "t4_tail");
        mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            ch_en = 4'($urandom);
            #1;
            check("t4_forced_comb");
            cycle("t4_forced");
        end
        mode  = 2'd3;
        ch_en = 4'hF;
        for (int i = 0; i < 10; i++) begin
            pulse = i[0];
            cycle("t4_off");
        end
        pulse = 1'b0;

        $display("T5 async reset mid-window, restart, 256-window wrap");
        mode     = 2'd0;
        az_width = 8'd5;
        pulse    = 1'b1;
        cycle("t5_trig");
        pulse = 1'b0;
        cycles(2, "t5_win");
        reset_b = 1'b0;
        model_reset();
        #1;
        check("t5_reset_async");
        cycles(2, "t5_reset_hold");
        reset_b = 1'b1;
        for (int i = 0; i < SP; i++) begin
            pulse = 1'b1;
            cycle("t5_startup_hi");
            pulse = 1'b0;
            cycle("t5_startup_lo");
        end
        az_width = 8'd1;
        for (int i = 0; i < 256; i++) begin
            pulse = 1'b1;
            cycle("t5_wrap_hi");
            pulse = 1'b0;
            cycle("t5_wrap_lo");
        end
        vectors++;
        assert (az_cnt === 8'h00) else begin
            miscompares++;
            $error("FAIL t5_wrap_final az_cnt: observed %0d expected 0", az_cnt);
        end

        $display("Random traffic: 30 segments");
        for (int s = 0; s < 30; s++) begin
            new_mode = $urandom_range(0, 3);
            mode     = 2'd3;
            period   = per_tab[$urandom_range(0, 4)];
            cycle("rnd_switch");
            mode = 2'(new_mode);
            for (int i = 0; i < 60; i++) begin
                pulse    = ($urandom_range(0, 3) == 0);
                az_width = 8'($urandom_range(0, 6));
                if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom);
                cycle("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
